// File: rtl/scoreboard_hazard_unit_pkg.sv
// Shared core constants: opcode encodings, hazard priority encoding and the
// stall/flush control word decoded from it.
package scoreboard_hazard_unit_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Highest-priority condition first: reset, memory stall, redirect,
  // scoreboard stall, front-end flush (JAL / no fetch data), idle.
  typedef enum logic [2:0] {
    PRI_IDLE,
    PRI_RESET,
    PRI_MEM,
    PRI_REDIRECT,
    PRI_SB,
    PRI_FRONT
  } hazard_pri_e;

  typedef struct packed {
    logic stall_decode;
    logic stall_execute;
    logic stall_memory;
    logic flush_decode;
    logic flush_execute;
    logic flush_writeback;
  } hazard_ctrl_t;

  function automatic logic opcode_writes_rd(input logic [6:0] opc);
    logic w;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_OP, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR:  w = 1'b1;
      OPC_STORE, OPC_BRANCH:         w = 1'b0;
      default:                       w = 1'b0;
    endcase
    return w;
  endfunction

  function automatic logic opcode_long_latency(input logic [6:0] opc);
    return opc == OPC_LOAD;
  endfunction

  function automatic hazard_pri_e hazard_priority(input logic rst,
                                                  input logic mem_stall,
                                                  input logic redirect,
                                                  input logic sb_stall,
                                                  input logic front_flush);
    hazard_pri_e p;
    if (rst)              p = PRI_RESET;
    else if (mem_stall)   p = PRI_MEM;
    else if (redirect)    p = PRI_REDIRECT;
    else if (sb_stall)    p = PRI_SB;
    else if (front_flush) p = PRI_FRONT;
    else                  p = PRI_IDLE;
    return p;
  endfunction

  function automatic hazard_ctrl_t hazard_ctrl(input hazard_pri_e pri);
    hazard_ctrl_t c;
    c = '0;
    case (pri)
      PRI_MEM: begin
        c.stall_decode    = 1'b1;
        c.stall_execute   = 1'b1;
        c.stall_memory    = 1'b1;
        c.flush_writeback = 1'b1;
      end
      PRI_REDIRECT: begin
        c.flush_decode  = 1'b1;
        c.flush_execute = 1'b1;
      end
      PRI_SB: begin
        c.stall_decode  = 1'b1;
        c.flush_execute = 1'b1;
      end
      PRI_FRONT: c.flush_decode = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/scoreboard_hazard_unit_pending_table.sv
// Pending-write bitmap and in-flight counter for long-latency destinations.
module sb_pending_table #(
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 set_valid_i,
  input  logic [$clog2(NUM_REGS)-1:0]          set_rd_i,
  input  logic                                 clr_valid_i,
  input  logic [$clog2(NUM_REGS)-1:0]          clr_rd_i,
  output logic [NUM_REGS-1:0]                  pending_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 sb_error_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [OW-1:0]       outstanding_q, outstanding_d;
  logic                error_q, error_d;
  logic                set_en, clr_en;

  // Next state: set on issue, clear on legal completion; bad completions only flag.
  always_comb begin
    set_en = set_valid_i & (set_rd_i != '0);
    clr_en = clr_valid_i & (clr_rd_i != '0) & pending_q[clr_rd_i];

    pending_d = pending_q;
    if (set_en) pending_d[set_rd_i] = 1'b1;
    if (clr_en) pending_d[clr_rd_i] = 1'b0;
    pending_d[0] = 1'b0;

    outstanding_d = outstanding_q;
    case ({set_en, clr_en})
      2'b10:   outstanding_d = outstanding_q + OW'(1);
      2'b01:   outstanding_d = outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    error_d = error_q | (clr_valid_i & ~clr_en);
  end

  // Scoreboard state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      error_q       <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      error_q       <= error_d;
    end
  end

  assign pending_o     = pending_q;
  assign outstanding_o = outstanding_q;
  assign sb_error_o    = error_q;

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Pipeline hazard unit: scoreboard RAW/WAW/capacity stalls combined with
// memory stall, execute redirect and front-end flush priorities.
module scoreboard_hazard_unit
  import scoreboard_hazard_unit_pkg::*;
#(
  parameter int CORE            = 0,
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 issue_valid,
  input  logic [$clog2(NUM_REGS)-1:0]          rs1,
  input  logic [$clog2(NUM_REGS)-1:0]          rs2,
  input  logic                                 rs1_read,
  input  logic                                 rs2_read,
  input  logic [$clog2(NUM_REGS)-1:0]          rd_decode,
  input  logic                                 regWrite_decode,
  input  logic                                 long_latency_decode,
  input  logic                                 complete_valid,
  input  logic [$clog2(NUM_REGS)-1:0]          complete_rd,
  input  logic                                 fetch_valid,
  input  logic                                 memory_ready,
  input  logic                                 memory_busy,
  input  logic                                 redirect_execute,
  input  logic                                 jal_decode,
  output logic                                 stall_decode,
  output logic                                 stall_execute,
  output logic                                 stall_memory,
  output logic                                 flush_decode,
  output logic                                 flush_execute,
  output logic                                 flush_writeback,
  output logic [NUM_REGS-1:0]                  pending,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 sb_error,
  input  logic                                 scan
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic         raw_hazard, waw_hazard, full_hazard, sb_stall, mem_stall;
  logic         fire, set_valid;
  hazard_pri_e  pri;
  hazard_ctrl_t ctrl;
  logic [31:0]  cycle_q;

  // Hazard detection, priority resolution and issue qualification.
  always_comb begin
    raw_hazard  = (rs1_read & pending[rs1] & (rs1 != '0))
                | (rs2_read & pending[rs2] & (rs2 != '0));
    waw_hazard  = regWrite_decode & (rd_decode != '0) & pending[rd_decode];
    full_hazard = long_latency_decode & regWrite_decode
                & (outstanding == OW'(MAX_OUTSTANDING));
    sb_stall    = issue_valid & (raw_hazard | waw_hazard | full_hazard);
    mem_stall   = memory_busy & ~memory_ready;
    pri         = hazard_priority(reset, mem_stall, redirect_execute, sb_stall,
                                  jal_decode | ~fetch_valid);
    ctrl        = hazard_ctrl(pri);
    fire        = issue_valid & ~ctrl.stall_decode & ~ctrl.flush_decode
                & ~mem_stall & ~redirect_execute;
    set_valid   = fire & long_latency_decode & regWrite_decode;
  end

  assign stall_decode    = ctrl.stall_decode;
  assign stall_execute   = ctrl.stall_execute;
  assign stall_memory    = ctrl.stall_memory;
  assign flush_decode    = ctrl.flush_decode;
  assign flush_execute   = ctrl.flush_execute;
  assign flush_writeback = ctrl.flush_writeback;

  sb_pending_table #(
    .NUM_REGS        (NUM_REGS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_table (
    .clock         (clock),
    .reset         (reset),
    .set_valid_i   (set_valid),
    .set_rd_i      (rd_decode),
    .clr_valid_i   (complete_valid),
    .clr_rd_i      (complete_rd),
    .pending_o     (pending),
    .outstanding_o (outstanding),
    .sb_error_o    (sb_error)
  );

  // Free-running cycle counter used to window the scan report.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_q + 32'd1;
  end

`ifndef SYNTHESIS
  localparam logic [31:0] SCAN_LO   = 32'(SCAN_CYCLES_MIN);
  localparam logic [31:0] SCAN_SPAN = 32'(SCAN_CYCLES_MAX - SCAN_CYCLES_MIN);

  // Simulation-only per-cycle state report; the unsigned offset compare
  // covers the whole [min, max] window in one test.
  always_ff @(posedge clock) begin
    if (!reset && scan && ((cycle_q - SCAN_LO) <= SCAN_SPAN))
      $display("core %0d cycle %0d pending %h outstanding %0d sd %b se %b sm %b fd %b fe %b fwb %b",
               CORE, cycle_q, pending, outstanding, stall_decode, stall_execute,
               stall_memory, flush_decode, flush_execute, flush_writeback);
  end
`endif

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for scoreboard_hazard_unit (NUM_REGS=32, MAX_OUTSTANDING=4).
module tb_scoreboard_hazard_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, rs1_read, rs2_read, regWrite_decode, long_latency_decode;
  logic [4:0]  rs1, rs2, rd_decode, complete_rd;
  logic        complete_valid, fetch_valid, memory_ready, memory_busy;
  logic        redirect_execute, jal_decode, scan;
  logic        stall_decode, stall_execute, stall_memory;
  logic        flush_decode, flush_execute, flush_writeback;
  logic [31:0] pending;
  logic [2:0]  outstanding;
  logic        sb_error;
  logic [5:0]  ctl;

  int n_checks = 0;
  int n_fail   = 0;

  scoreboard_hazard_unit #(
    .CORE            (0),
    .NUM_REGS        (32),
    .MAX_OUTSTANDING (4),
    .SCAN_CYCLES_MIN (0),
    .SCAN_CYCLES_MAX (1000)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .issue_valid         (issue_valid),
    .rs1                 (rs1),
    .rs2                 (rs2),
    .rs1_read            (rs1_read),
    .rs2_read            (rs2_read),
    .rd_decode           (rd_decode),
    .regWrite_decode     (regWrite_decode),
    .long_latency_decode (long_latency_decode),
    .complete_valid      (complete_valid),
    .complete_rd         (complete_rd),
    .fetch_valid         (fetch_valid),
    .memory_ready        (memory_ready),
    .memory_busy         (memory_busy),
    .redirect_execute    (redirect_execute),
    .jal_decode          (jal_decode),
    .stall_decode        (stall_decode),
    .stall_execute       (stall_execute),
    .stall_memory        (stall_memory),
    .flush_decode        (flush_decode),
    .flush_execute       (flush_execute),
    .flush_writeback     (flush_writeback),
    .pending             (pending),
    .outstanding         (outstanding),
    .sb_error            (sb_error),
    .scan                (scan)
  );

  // {stall_decode, stall_execute, stall_memory, flush_decode, flush_execute, flush_writeback}
  assign ctl = {stall_decode, stall_execute, stall_memory,
                flush_decode, flush_execute, flush_writeback};

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic quiet();
    issue_valid = 0; rs1 = 0; rs2 = 0; rs1_read = 0; rs2_read = 0;
    rd_decode = 0; regWrite_decode = 0; long_latency_decode = 0;
    complete_valid = 0; complete_rd = 0; fetch_valid = 1;
    memory_ready = 1; memory_busy = 0; redirect_execute = 0;
    jal_decode = 0; scan = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    issue_valid = 1; rd_decode = rd; regWrite_decode = 1; long_latency_decode = 1;
  endtask

  task automatic test_reset();
    quiet();
    memory_busy = 1; memory_ready = 0; jal_decode = 1; redirect_execute = 1;
    reset = 1;
    tick(); tick();
    n_checks++; if (ctl !== 6'b000000) begin n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b000000); end
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h expected %h", pending, 32'h0); end
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    n_checks++; if (sb_error !== 1'b0) begin n_fail++; $display("FAIL reset_sb_error: got %b expected 0", sb_error); end
    quiet();
    reset = 0;
    #1;
    n_checks++; if (ctl !== 6'b000000) begin n_fail++; $display("FAIL idle_ctl: got %b expected %b", ctl, 6'b000000); end
  endtask

  task automatic test_raw_load();
    tick();
    issue_long(5);
    #1;
    n_checks++; if (ctl !== 6'b000000) begin n_fail++; $display("FAIL load_issue_ctl: got %b expected %b", ctl, 6'b000000); end
    tick();
    n_checks++; if (pending !== 32'h0000_0020) begin n_fail++; $display("FAIL load_pending: got %h expected %h", pending, 32'h20); end
    n_checks++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL load_outstanding: got %0d expected 1", outstanding); end
    quiet();
    issue_valid = 1; rs1 = 5; rs1_read = 1;
    #1;
    n_checks++; if (ctl !== 6'b100010) begin n_fail++; $display("FAIL raw_stall: got %b expected %b", ctl, 6'b100010); end
    tick();
    n_checks++; if (ctl !== 6'b100010) begin n_fail++; $display("FAIL raw_stall_hold: got %b expected %b", ctl, 6'b100010); end
    complete_valid = 1; complete_rd = 5;
    #1;
    n_checks++; if (ctl !== 6'b100010) begin n_fail++; $display("FAIL raw_stall_on_complete: got %b expected %b", ctl, 6'b100010); end
    tick();
    complete_valid = 0;
    #1;
    n_checks++; if (ctl !== 6'b000000) begin n_fail++; $display("FAIL raw_release: got %b expected %b", ctl, 6'b000000); end
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL raw_release_outstanding: got %0d expected 0", outstanding); end
    quiet();
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) begin
      issue_long(5'(i));
      tick();
    end
    n_checks++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL full_outstanding: got %0d expected 4", outstanding); end
    n_checks++; if (pending !== 32'h0000_001E) begin n_fail++; $display("FAIL full_pending: got %h expected %h", pending, 32'h1E); end
    issue_long(6);
    #1;
    n_checks++; if (ctl !== 6'b100010) begin n_fail++; $display("FAIL full_stall: got %b expected %b", ctl, 6'b100010); end
    complete_valid = 1; complete_rd = 1;
    #1;
    n_checks++; if (ctl !== 6'b100010) begin n_fail++; $display("FAIL full_stall_on_complete: got %b expected %b", ctl, 6'b100010); end
    tick();
    complete_valid = 0;
    #1;
    n_checks++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL full_after_complete: got %0d expected 3", outstanding); end
    n_checks++; if (ctl !== 6'b000000) begin n_fail++; $display("FAIL full_fifth_fires: got %b expected %b", ctl, 6'b000000); end
    tick();
    n_checks++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL full_refilled: got %0d expected 4", outstanding); end
    n_checks++; if (pending !== 32'h0000_005C) begin n_fail++; $display("FAIL full_refill_pending: got %h expected %h", pending, 32'h5C); end
    quiet();
  endtask

  task automatic test_back_to_back();
    complete_valid = 1; complete_rd = 2;
    tick();
    complete_rd = 3;
    tick();
    complete_valid = 0;
    n_checks++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL b2b_drain: got %0d expected 2", outstanding); end
    n_checks++; if (pending !== 32'h0000_0050) begin n_fail++; $display("FAIL b2b_drain_pending: got %h expected %h", pending, 32'h50); end
    issue_long(8);
    complete_valid = 1; complete_rd = 4;
    #1;
    n_checks++; if (ctl !== 6'b000000) begin n_fail++; $display("FAIL b2b_ctl: got %b expected %b", ctl, 6'b000000); end
    tick();
    quiet();
    n_checks++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL b2b_outstanding: got %0d expected 2", outstanding); end
    n_checks++; if (pending !== 32'h0000_0140) begin n_fail++; $display("FAIL b2b_pending: got %h expected %h", pending, 32'h140); end
    complete_valid = 1; complete_rd = 6;
    tick();
    complete_rd = 8;
    tick();
    quiet();
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL b2b_final_outstanding: got %0d expected 0", outstanding); end
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL b2b_final_pending: got %h expected %h", pending, 32'h0); end
  endtask

  task automatic test_mem_priority();
    issue_long(3);
    tick();
    quiet();
    issue_long(10);
    rs1 = 3; rs1_read = 1;
    memory_busy = 1; memory_ready = 0; redirect_execute = 1;
    #1;
    n_checks++; if (ctl !== 6'b111001) begin n_fail++; $display("FAIL mem_over_redirect: got %b expected %b", ctl, 6'b111001); end
    tick();
    n_checks++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL mem_no_fire: got %0d expected 1", outstanding); end
    memory_ready = 1;
    #1;
    n_checks++; if (ctl !== 6'b000110) begin n_fail++; $display("FAIL busy_ready_redirect: got %b expected %b", ctl, 6'b000110); end
    tick();
    n_checks++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL redirect_no_fire: got %0d expected 1", outstanding); end
    quiet();
    complete_valid = 1; complete_rd = 3;
    tick();
    quiet();
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL mem_cleanup: got %0d expected 0", outstanding); end
  endtask

  task automatic test_redirect();
    issue_long(7);
    tick();
    quiet();
    issue_valid = 1; rs2 = 7; rs2_read = 1; redirect_execute = 1;
    #1;
    n_checks++; if (ctl !== 6'b000110) begin n_fail++; $display("FAIL redirect_over_sb: got %b expected %b", ctl, 6'b000110); end
    redirect_execute = 0;
    #1;
    n_checks++; if (ctl !== 6'b100010) begin n_fail++; $display("FAIL rs2_raw_stall: got %b expected %b", ctl, 6'b100010); end
    complete_valid = 1; complete_rd = 7;
    tick();
    quiet();
    #1;
    n_checks++; if (ctl !== 6'b000000) begin n_fail++; $display("FAIL redirect_cleanup_ctl: got %b expected %b", ctl, 6'b000000); end
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL redirect_cleanup: got %0d expected 0", outstanding); end
  endtask

  task automatic test_front_flush();
    quiet();
    jal_decode = 1;
    issue_long(12);
    #1;
    n_checks++; if (ctl !== 6'b000100) begin n_fail++; $display("FAIL jal_flush: got %b expected %b", ctl, 6'b000100); end
    tick();
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL jal_no_fire: got %0d expected 0", outstanding); end
    jal_decode = 0; fetch_valid = 0;
    #1;
    n_checks++; if (ctl !== 6'b000100) begin n_fail++; $display("FAIL nofetch_flush: got %b expected %b", ctl, 6'b000100); end
    tick();
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL nofetch_no_fire: got %0d expected 0", outstanding); end
    quiet();
    #1;
    n_checks++; if (ctl !== 6'b000000) begin n_fail++; $display("FAIL front_idle: got %b expected %b", ctl, 6'b000000); end
  endtask

  task automatic test_error_reset();
    quiet();
    n_checks++; if (sb_error !== 1'b0) begin n_fail++; $display("FAIL err_clean: got %b expected 0", sb_error); end
    issue_long(11);
    tick();
    quiet();
    complete_valid = 1; complete_rd = 9;
    tick();
    quiet();
    n_checks++; if (sb_error !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", sb_error); end
    n_checks++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL err_outstanding: got %0d expected 1", outstanding); end
    n_checks++; if (pending !== 32'h0000_0800) begin n_fail++; $display("FAIL err_pending: got %h expected %h", pending, 32'h800); end
    tick();
    n_checks++; if (sb_error !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", sb_error); end
    #2;
    reset = 1;
    #1;
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL async_reset_pending: got %h expected %h", pending, 32'h0); end
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL async_reset_outstanding: got %0d expected 0", outstanding); end
    n_checks++; if (sb_error !== 1'b0) begin n_fail++; $display("FAIL async_reset_sb_error: got %b expected 0", sb_error); end
    #2;
    reset = 0;
    complete_valid = 1; complete_rd = 11;
    tick();
    quiet();
    n_checks++; if (sb_error !== 1'b1) begin n_fail++; $display("FAIL late_complete_error: got %b expected 1", sb_error); end
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL late_complete_outstanding: got %0d expected 0", outstanding); end
    reset = 1;
    #1;
    reset = 0;
    #1;
    issue_long(0);
    tick();
    quiet();
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL r0_issue_outstanding: got %0d expected 0", outstanding); end
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL r0_issue_pending: got %h expected %h", pending, 32'h0); end
    complete_valid = 1; complete_rd = 0;
    tick();
    quiet();
    n_checks++; if (sb_error !== 1'b1) begin n_fail++; $display("FAIL r0_complete_error: got %b expected 1", sb_error); end
  endtask

  initial begin
    test_reset();
    test_raw_load();
    test_full();
    test_back_to_back();
    test_mem_priority();
    test_redirect();
    test_front_flush();
    test_error_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
